perfect_ctrl: RTL and testbench

PERFECT_CTRL -- requirements
Module: perfect_ctrl

---
 rtl/perfect_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_perfect_ctrl.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/perfect_ctrl.sv
// perfect_ctrl: Moore controller for a perfect-number checker. For each
// candidate i in 1..n-1 it drives a repeated-subtraction divider to test
// whether i divides n, accumulates the divisors into sum, and finally
// compares sum against n.
// Optional feature: define PERFECT_CTRL_CYCLE_CNT_EN to build the 16-bit
// per-check cycle counter presented on 'cycles'; otherwise 'cycles' is 0.
module perfect_ctrl (
    input  logic        clk,
    input  logic        clr_n,
    input  logic        start,
    input  logic        lt_n,
    input  logic        sum_eq,
    input  logic        n_zero,
    input  logic        rem_ge,
    input  logic        rem_zero,
    output logic        ldN,
    output logic        ldI,
    output logic        ldSum,
    output logic        sel,
    output logic        TN,
    output logic        TS,
    output logic [2:0]  fselect,
    output logic        ldRem,
    output logic        ldDivor,
    output logic        ldQuot,
    output logic        sel1,
    output logic [2:0]  fselect_d,
    output logic        busy,
    output logic        done,
    output logic        perfect,
    output logic [15:0] cycles
);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_LOAD     = 4'd1,
        S_TEST     = 4'd2,
        S_DIV_INIT = 4'd3,
        S_DIV_SUB  = 4'd4,
        S_ACC_CHK  = 4'd5,
        S_ACCUM    = 4'd6,
        S_INC      = 4'd7,
        S_CMP      = 4'd8,
        S_DONE     = 4'd9
    } state_t;

    state_t     state_q, state_d;
    logic       ldn_q, ldn_d;
    logic       ldi_q, ldi_d;
    logic       ldsum_q, ldsum_d;
    logic       sel_q, sel_d;
    logic       ts_q, ts_d;
    logic [2:0] fsel_q, fsel_d;
    logic       div_init_q, div_init_d;
    logic       div_sub_q, div_sub_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       perfect_q, perfect_d;
    logic       sub_en;

    // Next state, result update and output decode of the state being entered
    always_comb begin
        state_d   = S_IDLE;
        perfect_d = perfect_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_LOAD;
                    perfect_d = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD:     state_d = S_TEST;
            S_TEST:     state_d = lt_n ? S_DIV_INIT : S_CMP;
            S_DIV_INIT: state_d = S_DIV_SUB;
            S_DIV_SUB:  state_d = rem_ge ? S_DIV_SUB : S_ACC_CHK;
            S_ACC_CHK:  state_d = rem_zero ? S_ACCUM : S_INC;
            S_ACCUM:    state_d = S_INC;
            S_INC:      state_d = S_TEST;
            S_CMP: begin
                state_d   = S_DONE;
                perfect_d = sum_eq & ~n_zero;
            end
            S_DONE:     state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase

        ldn_d      = (state_d == S_LOAD);
        ldi_d      = (state_d == S_LOAD) || (state_d == S_INC);
        ldsum_d    = (state_d == S_LOAD) || (state_d == S_ACCUM);
        sel_d      = (state_d == S_ACCUM) || (state_d == S_INC);
        ts_d       = (state_d == S_ACCUM);
        fsel_d     = (state_d == S_ACCUM) ? 3'b001 :
                     (state_d == S_INC)   ? 3'b011 : 3'b000;
        div_init_d = (state_d == S_DIV_INIT);
        div_sub_d  = (state_d == S_DIV_SUB);
        busy_d     = (state_d != S_IDLE);
        done_d     = (state_d == S_DONE);
    end

    // State register with outputs registered alongside it
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q    <= S_IDLE;
            ldn_q      <= 1'b0;
            ldi_q      <= 1'b0;
            ldsum_q    <= 1'b0;
            sel_q      <= 1'b0;
            ts_q       <= 1'b0;
            fsel_q     <= 3'b000;
            div_init_q <= 1'b0;
            div_sub_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            perfect_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ldn_q      <= ldn_d;
            ldi_q      <= ldi_d;
            ldsum_q    <= ldsum_d;
            sel_q      <= sel_d;
            ts_q       <= ts_d;
            fsel_q     <= fsel_d;
            div_init_q <= div_init_d;
            div_sub_q  <= div_sub_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            perfect_q  <= perfect_d;
        end
    end

    // In DIV_SUB the subtract-and-load happens only while rem >= divisor
    assign sub_en    = div_sub_q & rem_ge;

    assign ldN       = ldn_q;
    assign ldI       = ldi_q;
    assign ldSum     = ldsum_q;
    assign sel       = sel_q;
    assign TN        = 1'b0;
    assign TS        = ts_q;
    assign fselect   = fsel_q;
    assign ldRem     = div_init_q | sub_en;
    assign ldDivor   = div_init_q;
    assign ldQuot    = div_init_q;
    assign sel1      = sub_en;
    assign fselect_d = sub_en ? 3'b010 : 3'b000;
    assign busy      = busy_q;
    assign done      = done_q;
    assign perfect   = perfect_q;

`ifdef PERFECT_CTRL_CYCLE_CNT_EN
    logic [15:0] cnt_q, cnt_d, cnt_inc;
    logic [15:0] cycles_q, cycles_d;

    // Saturating busy-cycle counter; the total including the DONE cycle is latched
    always_comb begin
        cnt_inc  = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
        cnt_d    = cnt_q;
        cycles_d = cycles_q;
        if (state_q == S_IDLE) begin
            if (start) begin
                cnt_d = 16'd0;
            end
        end else begin
            cnt_d = cnt_inc;
        end
        if (state_q == S_DONE) begin
            cycles_d = cnt_inc;
        end
    end

    // Counter and latched result registers
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            cnt_q    <= 16'd0;
            cycles_q <= 16'd0;
        end else begin
            cnt_q    <= cnt_d;
            cycles_q <= cycles_d;
        end
    end

    assign cycles = cycles_q;
`else
    assign cycles = 16'd0;
`endif

endmodule

// File: tb/tb_perfect_ctrl.sv
// tb_perfect_ctrl: drives perfect_ctrl with a behavioural checker/divider
// datapath, randomized and directed candidates, and a scoreboard that checks
// each done pulse against an arithmetic perfect-number reference.
module tb_perfect_ctrl;

    logic        clk;
    logic        clr_n;
    logic        start;
    logic        lt_n, sum_eq, n_zero, rem_ge, rem_zero;
    logic        ldN, ldI, ldSum, sel, TN, TS;
    logic [2:0]  fselect;
    logic        ldRem, ldDivor, ldQuot, sel1;
    logic [2:0]  fselect_d;
    logic        busy, done, perfect;
    logic [15:0] cycles;

    perfect_ctrl dut (
        .clk       (clk),
        .clr_n     (clr_n),
        .start     (start),
        .lt_n      (lt_n),
        .sum_eq    (sum_eq),
        .n_zero    (n_zero),
        .rem_ge    (rem_ge),
        .rem_zero  (rem_zero),
        .ldN       (ldN),
        .ldI       (ldI),
        .ldSum     (ldSum),
        .sel       (sel),
        .TN        (TN),
        .TS        (TS),
        .fselect   (fselect),
        .ldRem     (ldRem),
        .ldDivor   (ldDivor),
        .ldQuot    (ldQuot),
        .sel1      (sel1),
        .fselect_d (fselect_d),
        .busy      (busy),
        .done      (done),
        .perfect   (perfect),
        .cycles    (cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural datapath ----------------
    int x_in;
    int n_r, i_r, sum_r, rem_r, div_r;

    function automatic int alu(logic [2:0] op, int a, int b);
        case (op)
            3'b001:  return a + b;
            3'b010:  return a - b;
            3'b011:  return b + 1;
            default: return 0;
        endcase
    endfunction

    always @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            n_r <= 0; i_r <= 0; sum_r <= 0; rem_r <= 0; div_r <= 0;
        end else begin
            if (ldN)     n_r   <= x_in;
            if (ldI)     i_r   <= sel ? alu(fselect, 0, i_r) : 1;
            if (ldSum)   sum_r <= sel ? alu(fselect, sum_r, i_r) : 0;
            if (ldRem)   rem_r <= sel1 ? alu(fselect_d, rem_r, div_r) : n_r;
            if (ldDivor) div_r <= i_r;
        end
    end

    assign lt_n     = (i_r < n_r);
    assign sum_eq   = (sum_r == n_r);
    assign n_zero   = (n_r == 0);
    assign rem_ge   = (rem_r >= div_r);
    assign rem_zero = (rem_r == 0);

    // ---------------- reference model ----------------
    function automatic bit ref_perfect(int x);
        int s = 0;
        for (int d = 1; d < x; d++) if (x % d == 0) s += d;
        return (x != 0) && (s == x);
    endfunction

    // Cycle cost: LOAD + final TEST/CMP/DONE, plus per candidate i:
    // TEST, DIV_INIT, x/i subtracts + 1 exit, ACC_CHK, INC, and ACCUM if i | x.
    function automatic int ref_cycles(int x);
`ifdef PERFECT_CTRL_CYCLE_CNT_EN
        longint c = 4;
        for (int i = 1; i < x; i++) c += 5 + x / i + ((x % i == 0) ? 1 : 0);
        return (c > 65535) ? 65535 : int'(c);
`else
        return (x < 0) ? 1 : 0;
`endif
    endfunction

    typedef struct {
        int x;
        bit perf;
        int cyc;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    task automatic chk(string name, int act, int expv);
        vectors++;
        if (act != expv) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    function automatic exp_t mk(int x);
        exp_t e;
        e.x = x;
        e.perf = ref_perfect(x);
        e.cyc = ref_cycles(x);
        return e;
    endfunction

    // ---------------- monitor ----------------
    bit   cyc_pending = 0;
    exp_t cur;

    always @(negedge clk) begin
        if (cyc_pending) begin
            cyc_pending = 0;
            if (clr_n) chk("cycles", int'(cycles), cur.cyc);
        end
        if (clr_n && done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                cur = sb.pop_front();
                $display("check x=%0d perfect=%0b expected=%0b", cur.x, perfect, cur.perf);
                chk("perfect", int'(perfect), int'(cur.perf));
                cyc_pending = 1;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_done(output int lat);
        lat = 0;
        for (int k = 0; k < 20000; k++) begin
            @(negedge clk);
            if (busy) lat++;
            if (done) return;
        end
        chk("done_timeout", 0, 1);
    endtask

    task automatic run(int x, output int lat);
        int w;
        @(negedge clk);
        x_in  = x;
        start = 1'b1;
        sb.push_back(mk(x));
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        chk("load_ctl", int'({ldN, ldI, ldSum, sel, TS, fselect, busy}), 9'b111000001);
        chk("perfect_clr", int'(perfect), 0);
        wait_done(w);
        lat = 1 + w;
    endtask

    function automatic int all_outs();
        return int'({ldN, ldI, ldSum, sel, TN, TS, fselect, ldRem, ldDivor,
                     ldQuot, sel1, fselect_d, busy, done, perfect}) | int'(cycles);
    endfunction

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int xs [6] = '{6, 28, 12, 0, 1, 496};
        clr_n = 1'b1;
        start = 1'b0;
        x_in  = 0;
        #3 clr_n = 1'b0;
        #2 chk("reset_outputs", all_outs(), 0);
        repeat (2) @(negedge clk);
        chk("reset_hold", all_outs(), 0);
        clr_n = 1'b1;

        // directed: known perfect and non-perfect values, boundaries
        foreach (xs[k]) begin
            run(xs[k], lat);
            if (xs[k] == 1) chk("latency_x1", lat, 4);
            @(negedge clk);
            chk("busy_after_done", int'({busy, done}), 0);
        end

        // second start while busy is ignored
        run_ignored_start();

        // start held across DONE starts a new check right after IDLE
        @(negedge clk);
        x_in  = 6;
        start = 1'b1;
        sb.push_back(mk(6));
        sb.push_back(mk(6));
        wait_done(lat);
        @(negedge clk);
        chk("hold_idle", int'(busy), 0);
        @(negedge clk);
        chk("hold_restart", int'(busy), 1);
        start = 1'b0;
        wait_done(lat);

        // reset in the middle of a division
        @(negedge clk);
        x_in  = 28;
        start = 1'b1;
        sb.push_back(mk(28));
        @(posedge clk);
        #1 start = 1'b0;
        begin
            bit seen = 0;
            for (int k = 0; k < 2000 && !seen; k++) begin
                @(negedge clk);
                if (ldRem && sel1 && ldN == 1'b0) seen = 1;
            end
            chk("reach_div_sub", int'(seen), 1);
        end
        clr_n = 1'b0;
        sb.delete();
        #1 chk("midrun_reset", all_outs(), 0);
        @(negedge clk);
        clr_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("idle_after_reset", int'({busy, done}), 0);
        run(6, lat);

        // randomized candidates
        for (int r = 0; r < 16; r++) begin
            run(int'($urandom_range(0, 40)), lat);
            repeat ($urandom_range(1, 3)) @(negedge clk);
            chk("rand_idle", int'(busy), 0);
        end

        repeat (20) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    task automatic run_ignored_start();
        int lat;
        @(negedge clk);
        x_in  = 28;
        start = 1'b1;
        sb.push_back(mk(28));
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat);
        repeat (30) @(negedge clk);
        chk("ignored_start_idle", int'(busy), 0);
        chk("result_held", int'(perfect), 1);
    endtask

endmodule
